// File: rtl/connect4_pkg.sv
// -----------------------------------------------------------------------------
// connect4_pkg
// Shared types and width helpers for the Connect-4 turn timer.
//   timer_state_t  : IDLE / RUN / PAUSED / EXPIRED
//   player_width() : bits needed for the player index, never less than 1
//   seconds_width(): bits needed to hold 0..TIMEOUT_S
// -----------------------------------------------------------------------------
package connect4_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  function automatic int player_width(input int n_players);
    return (n_players <= 2) ? 1 : $clog2(n_players);
  endfunction

  function automatic int seconds_width(input int timeout_s);
    return $clog2(timeout_s + 1);
  endfunction

endpackage

// File: rtl/connect4_turn_timer_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock down to a one-second tick.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   en   : count this cycle (timer is running)
//   clr  : force the count back to 0 (wins over en)
//   tick : high in the cycle where the count sits at CLK_HZ-1 while enabled;
//          the count wraps to 0 on that same edge
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // tick depends only on registered count and the enable, which the parent
  // derives from its state register, so no input reaches tick directly.
  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/connect4_turn_timer.sv
// -----------------------------------------------------------------------------
// connect4_turn_timer
// Per-turn countdown timer with N-player rotation, pause, abort and a choice of
// auto-pass or halt on timeout.
//
// Parameters:
//   CLK_HZ    : clock cycles per second (>= 2)
//   TIMEOUT_S : turn length in seconds (>= 1)
//   WARN_S    : warn threshold in seconds (< TIMEOUT_S)
//   N_PLAYERS : players in rotation (>= 2)
//   AUTO_PASS : 1 = pass the turn and keep running on timeout, 0 = halt
//
// Ports:
//   clk          : system clock
//   rst          : asynchronous active-low reset
//   start        : pulse, begins or re-arms a turn from IDLE or EXPIRED
//   abort        : synchronous return to IDLE from any state
//   pause        : level, freezes the countdown while in RUN
//   move_valid   : pulse, current player made a legal move
//   player       : index of the current player
//   seconds_left : remaining whole seconds of the current turn
//   warn         : RUN/PAUSED with seconds_left <= WARN_S
//   done         : one-cycle timeout pulse
//   state_dbg    : current FSM state, for observation only
//
// Event priority each cycle: abort > start > move_valid > tick > pause.
// All outputs come from registers or a decode of registers only.
// -----------------------------------------------------------------------------
module connect4_turn_timer
  import connect4_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TIMEOUT_S = 15,
  parameter int WARN_S    = 5,
  parameter int N_PLAYERS = 2,
  parameter int AUTO_PASS = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic                                   pause,
  input  logic                                   move_valid,
  output logic [player_width(N_PLAYERS)-1:0]     player,
  output logic [seconds_width(TIMEOUT_S)-1:0]    seconds_left,
  output logic                                   warn,
  output logic                                   done,
  output timer_state_t                           state_dbg
);

  localparam int PW = player_width(N_PLAYERS);
  localparam int SW = seconds_width(TIMEOUT_S);

  localparam logic [SW-1:0] TIMEOUT_V = SW'(TIMEOUT_S);
  localparam logic [SW-1:0] WARN_V    = SW'(WARN_S);
  localparam logic [SW-1:0] ONE_S     = SW'(1);
  localparam logic [PW-1:0] LAST_P    = PW'(N_PLAYERS - 1);

  timer_state_t  state_q;
  logic [PW-1:0] player_q;
  logic [SW-1:0] seconds_q;
  logic          done_q;

  logic          start_ok;
  logic          presc_en;
  logic          presc_clr;
  logic          tick;
  logic [PW-1:0] next_player;

  // start is only honoured when no turn is in progress.
  assign start_ok = start && ((state_q == IDLE) || (state_q == EXPIRED));

  assign next_player = (player_q == LAST_P) ? '0 : player_q + PW'(1);

  // The prescaler only advances in RUN, so PAUSED cycles push the deadline
  // out one cycle each and resume from the held count. On a timeout the
  // prescaler wraps to 0 on its own, so no explicit clear is needed there.
  assign presc_en  = (state_q == RUN);
  assign presc_clr = abort || start_ok || ((state_q == RUN) && move_valid);

  tick_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (presc_en),
    .clr (presc_clr),
    .tick(tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      player_q  <= '0;
      seconds_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q   <= IDLE;
        seconds_q <= '0;
      end else if (start_ok) begin
        state_q   <= RUN;
        seconds_q <= TIMEOUT_V;
      end else begin
        case (state_q)
          RUN: begin
            if (move_valid) begin
              // A move on the final tick wins: the turn passes without done.
              player_q  <= next_player;
              seconds_q <= TIMEOUT_V;
            end else if (tick) begin
              if (seconds_q == ONE_S) begin
                done_q   <= 1'b1;
                player_q <= next_player;
                if (AUTO_PASS != 0) begin
                  seconds_q <= TIMEOUT_V;
                end else begin
                  seconds_q <= '0;
                  state_q   <= EXPIRED;
                end
              end else begin
                seconds_q <= seconds_q - ONE_S;
              end
            end else if (pause) begin
              state_q <= PAUSED;
            end
          end
          PAUSED: begin
            if (!pause) begin
              state_q <= RUN;
            end
          end
          default: begin
            // IDLE and EXPIRED wait for start or abort.
          end
        endcase
      end
    end
  end

  assign player       = player_q;
  assign seconds_left = seconds_q;
  assign done         = done_q;
  assign state_dbg    = state_q;
  assign warn         = ((state_q == RUN) || (state_q == PAUSED)) && (seconds_q <= WARN_V);

endmodule

// File: tb/tb_connect4_turn_timer.sv
module tb_connect4_turn_timer;
  import connect4_pkg::*;

  localparam int CLK_HZ    = 4;
  localparam int TIMEOUT_S = 3;
  localparam int WARN_S    = 1;
  localparam int N_PLAYERS = 3;
  localparam int PW        = player_width(N_PLAYERS);
  localparam int SW        = seconds_width(TIMEOUT_S);
  localparam int W         = 2 + PW + SW + 2;

  // ---------------- clock / reset ----------------
  logic clk        = 1'b0;
  logic rst        = 1'b0;
  logic start      = 1'b0;
  logic abort      = 1'b0;
  logic pause      = 1'b0;
  logic move_valid = 1'b0;

  always #10 clk = ~clk;

  logic [PW-1:0] player_a, player_b;
  logic [SW-1:0] sec_a, sec_b;
  logic          warn_a, warn_b, done_a, done_b;
  timer_state_t  state_a, state_b;

  connect4_turn_timer #(
    .CLK_HZ(CLK_HZ), .TIMEOUT_S(TIMEOUT_S), .WARN_S(WARN_S),
    .N_PLAYERS(N_PLAYERS), .AUTO_PASS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .move_valid(move_valid), .player(player_a), .seconds_left(sec_a),
    .warn(warn_a), .done(done_a), .state_dbg(state_a)
  );

  connect4_turn_timer #(
    .CLK_HZ(CLK_HZ), .TIMEOUT_S(TIMEOUT_S), .WARN_S(WARN_S),
    .N_PLAYERS(N_PLAYERS), .AUTO_PASS(0)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .move_valid(move_valid), .player(player_b), .seconds_left(sec_b),
    .warn(warn_b), .done(done_b), .state_dbg(state_b)
  );

  int checks    = 0;
  int errors    = 0;
  int now       = 0;
  int done_seen = 0;

  // ---------------- reference model ----------------
  // Tracks elapsed RUN cycles within the turn; seconds_left is derived from
  // that count arithmetically. Index 0 models auto-pass, index 1 halts.
  timer_state_t m_st[2];
  int           m_pl[2];
  int           m_e[2];
  logic         m_done[2];
  int           m_auto[2] = '{1, 0};

  task automatic model_reset(input int i);
    m_st[i]   = IDLE;
    m_pl[i]   = 0;
    m_e[i]    = 0;
    m_done[i] = 1'b0;
  endtask

  task automatic model_step(input int i);
    m_done[i] = 1'b0;
    if (abort) begin
      m_st[i] = IDLE;
      m_e[i]  = 0;
    end else if (start && (m_st[i] == IDLE || m_st[i] == EXPIRED)) begin
      m_st[i] = RUN;
      m_e[i]  = 0;
    end else if (m_st[i] == RUN) begin
      if (move_valid) begin
        m_pl[i] = (m_pl[i] + 1) % N_PLAYERS;
        m_e[i]  = 0;
      end else if (m_e[i] == TIMEOUT_S * CLK_HZ - 1) begin
        m_done[i] = 1'b1;
        m_pl[i]   = (m_pl[i] + 1) % N_PLAYERS;
        m_e[i]    = 0;
        if (m_auto[i] == 0) m_st[i] = EXPIRED;
      end else begin
        // a one-second boundary outranks pause in the same cycle
        if (pause && (m_e[i] % CLK_HZ) != CLK_HZ - 1) m_st[i] = PAUSED;
        m_e[i] = m_e[i] + 1;
      end
    end else if (m_st[i] == PAUSED) begin
      if (!pause) m_st[i] = RUN;
    end
  endtask

  function automatic logic [W-1:0] model_vec(input int i);
    int   s;
    logic act;
    logic wn;
    act = (m_st[i] == RUN) || (m_st[i] == PAUSED);
    s   = act ? (TIMEOUT_S - m_e[i] / CLK_HZ) : 0;
    wn  = act && (s <= WARN_S);
    return {m_st[i], PW'(m_pl[i]), SW'(s), wn, m_done[i]};
  endfunction

  function automatic logic [W-1:0] dut_vec(input int i);
    if (i == 0) return {state_a, player_a, sec_a, warn_a, done_a};
    return {state_b, player_b, sec_b, warn_b, done_b};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic s, input logic a, input logic p, input logic m);
    start      = s;
    abort      = a;
    pause      = p;
    move_valid = m;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) model_reset(i);
      else      model_step(i);
    end
    #1;
    now = now + 1;
    if (done_a) done_seen = done_seen + 1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) model_reset(i);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    rst = 1'b1;
  endtask

  // Leaves the bench in cycle t, the first RUN cycle of a fresh turn.
  task automatic begin_turn();
    apply_reset();
    cycle(1, 0, 0, 0);
    now       = 0;
    done_seen = 0;
  endtask

  task automatic run_to(input int n);
    while (now < n) cycle(0, 0, 0, 0);
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++; if (player_a !== '0) begin errors++; $display("FAIL reset_player got %0d exp 0", player_a); end
    checks++; if (sec_a !== '0) begin errors++; $display("FAIL reset_seconds got %0d exp 0", sec_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done_a); end
    checks++; if (warn_a !== 1'b0) begin errors++; $display("FAIL reset_warn got %0b exp 0", warn_a); end
    checks++; if (state_a !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state_a, IDLE); end
    checks++; if (state_b !== IDLE) begin errors++; $display("FAIL reset_state_b got %0d exp %0d", state_b, IDLE); end
    cycle(1, 0, 0, 0);
    checks++; if (sec_a !== SW'(3)) begin errors++; $display("FAIL start_seconds got %0d exp 3", sec_a); end
    checks++; if (state_a !== RUN) begin errors++; $display("FAIL start_state got %0d exp %0d", state_a, RUN); end
  endtask

  task automatic test_timeout();
    begin_turn();
    run_to(4);
    checks++; if (sec_a !== SW'(2)) begin errors++; $display("FAIL timeout_sec_t4 got %0d exp 2", sec_a); end
    run_to(7);
    checks++; if (warn_a !== 1'b0) begin errors++; $display("FAIL timeout_warn_t7 got %0b exp 0", warn_a); end
    run_to(8);
    checks++; if (sec_a !== SW'(1)) begin errors++; $display("FAIL timeout_sec_t8 got %0d exp 1", sec_a); end
    checks++; if (warn_a !== 1'b1) begin errors++; $display("FAIL timeout_warn_t8 got %0b exp 1", warn_a); end
    run_to(11);
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL timeout_early_done got %0d exp 0", done_seen); end
    run_to(12);
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL timeout_done_t12 got %0b exp 1", done_a); end
    checks++; if (player_a !== PW'(1)) begin errors++; $display("FAIL timeout_player_t12 got %0d exp 1", player_a); end
    checks++; if (sec_a !== SW'(3)) begin errors++; $display("FAIL timeout_sec_t12 got %0d exp 3", sec_a); end
    run_to(13);
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL timeout_done_t13 got %0b exp 0", done_a); end
    run_to(24);
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL timeout_done_t24 got %0b exp 1", done_a); end
    checks++; if (player_a !== PW'(2)) begin errors++; $display("FAIL timeout_player_t24 got %0d exp 2", player_a); end
    checks++; if (done_seen !== 2) begin errors++; $display("FAIL timeout_count_t24 got %0d exp 2", done_seen); end
    run_to(36);
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL timeout_done_t36 got %0b exp 1", done_a); end
    checks++; if (player_a !== PW'(0)) begin errors++; $display("FAIL timeout_player_wrap got %0d exp 0", player_a); end
    checks++; if (done_seen !== 3) begin errors++; $display("FAIL timeout_count_t36 got %0d exp 3", done_seen); end
  endtask

  task automatic test_move();
    begin_turn();
    run_to(6);
    cycle(0, 0, 0, 1);
    checks++; if (player_a !== PW'(1)) begin errors++; $display("FAIL move_player got %0d exp 1", player_a); end
    checks++; if (sec_a !== SW'(3)) begin errors++; $display("FAIL move_seconds got %0d exp 3", sec_a); end
    run_to(18);
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL move_early_done got %0d exp 0", done_seen); end
    run_to(19);
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL move_done_t19 got %0b exp 1", done_a); end
    checks++; if (player_a !== PW'(2)) begin errors++; $display("FAIL move_player_t19 got %0d exp 2", player_a); end
  endtask

  task automatic test_back_to_back();
    // move lands on the very cycle of the final tick
    begin_turn();
    run_to(11);
    cycle(0, 0, 0, 1);
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL simul_done got %0b exp 0", done_a); end
    checks++; if (player_a !== PW'(1)) begin errors++; $display("FAIL simul_player got %0d exp 1", player_a); end
    checks++; if (sec_a !== SW'(3)) begin errors++; $display("FAIL simul_seconds got %0d exp 3", sec_a); end
    run_to(16);
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL simul_any_done got %0d exp 0", done_seen); end
  endtask

  task automatic test_pause_abort();
    begin_turn();
    run_to(2);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0);
    checks++; if (state_a !== PAUSED) begin errors++; $display("FAIL pause_state got %0d exp %0d", state_a, PAUSED); end
    checks++; if (sec_a !== SW'(3)) begin errors++; $display("FAIL pause_seconds got %0d exp 3", sec_a); end
    for (int k = 0; k < 2; k++) cycle(0, 0, 1, 0);
    run_to(9);
    checks++; if (state_a !== RUN) begin errors++; $display("FAIL pause_resume got %0d exp %0d", state_a, RUN); end
    checks++; if (sec_a !== SW'(2)) begin errors++; $display("FAIL pause_sec_t9 got %0d exp 2", sec_a); end
    run_to(16);
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL pause_early_done got %0d exp 0", done_seen); end
    run_to(17);
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL pause_done_t17 got %0b exp 1", done_a); end
    cycle(0, 1, 0, 0);
    checks++; if (state_a !== IDLE) begin errors++; $display("FAIL abort_state got %0d exp %0d", state_a, IDLE); end
    checks++; if (sec_a !== '0) begin errors++; $display("FAIL abort_seconds got %0d exp 0", sec_a); end
    checks++; if (player_a !== PW'(1)) begin errors++; $display("FAIL abort_player got %0d exp 1", player_a); end
    checks++; if (warn_a !== 1'b0) begin errors++; $display("FAIL abort_warn got %0b exp 0", warn_a); end
  endtask

  task automatic test_expired();
    begin_turn();
    run_to(11);
    checks++; if (sec_b !== SW'(1)) begin errors++; $display("FAIL halt_sec_t11 got %0d exp 1", sec_b); end
    run_to(12);
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL halt_done got %0b exp 1", done_b); end
    checks++; if (state_b !== EXPIRED) begin errors++; $display("FAIL halt_state got %0d exp %0d", state_b, EXPIRED); end
    checks++; if (sec_b !== '0) begin errors++; $display("FAIL halt_seconds got %0d exp 0", sec_b); end
    checks++; if (player_b !== PW'(1)) begin errors++; $display("FAIL halt_player got %0d exp 1", player_b); end
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    checks++; if (player_b !== PW'(1)) begin errors++; $display("FAIL halt_move_ignored got %0d exp 1", player_b); end
    checks++; if (state_b !== EXPIRED) begin errors++; $display("FAIL halt_hold got %0d exp %0d", state_b, EXPIRED); end
    checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL halt_done_once got %0b exp 0", done_b); end
    cycle(1, 0, 0, 0);
    checks++; if (sec_b !== SW'(3)) begin errors++; $display("FAIL halt_restart got %0d exp 3", sec_b); end
    checks++; if (state_b !== RUN) begin errors++; $display("FAIL halt_restart_state got %0d exp %0d", state_b, RUN); end
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0);
    checks++; if (sec_b !== SW'(2)) begin errors++; $display("FAIL halt_count got %0d exp 2", sec_b); end
  endtask

  task automatic test_random();
    logic         s, a, p, m;
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    apply_reset();
    p = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      s = ($urandom_range(0, 99) < 6);
      a = ($urandom_range(0, 99) < 2);
      m = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 9) == 0) p = ~p;
      cycle(s, a, p, m);
      exp_q.push_back(model_vec(0));
      exp_q.push_back(model_vec(1));
      for (int i = 0; i < 2; i++) begin
        exp_v = exp_q.pop_front();
        got_v = dut_vec(i);
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL random dut%0d cycle %0d got %b exp %b", i, n, got_v, exp_v);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_timeout();
    test_move();
    test_back_to_back();
    test_pause_abort();
    test_expired();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
